// File: rtl/mem_io_bridge.sv
// Byte-bus bridge between the CPU and block RAM / memory-mapped UART, cycle counter and halt latch.
// Optional MEM_IO_CLK_SNAPSHOT_EN: a read of 0x30004 latches the whole counter so 4-byte reads are coherent.
module mem_io_bridge #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH_LOG   = 3,
    parameter int FULL_MARGIN    = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic [31:0]               mem_a,
    input  logic [7:0]                mem_dout,
    input  logic                      mem_wr,
    output logic [7:0]                mem_din,
    output logic                      io_buffer_full,
    output logic [RAM_ADDR_WIDTH-1:0] ram_a,
    output logic [7:0]                ram_dout,
    output logic                      ram_we,
    input  logic [7:0]                ram_din,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic                      rx_pop,
    output logic                      halted
);
    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG;
    localparam logic [TX_DEPTH_LOG:0] DEPTH_C  = (TX_DEPTH_LOG + 1)'(TX_DEPTH);
    localparam logic [TX_DEPTH_LOG:0] MARGIN_C = (TX_DEPTH_LOG + 1)'(FULL_MARGIN);

    typedef enum logic [1:0] {SEL_ZERO, SEL_RAM, SEL_RX, SEL_CNT} rd_sel_e;

    rd_sel_e                   rd_sel_q, rd_sel_d;
    logic [7:0]                rx_byte_q, rx_byte_d;
    logic [7:0]                cnt_byte_q, cnt_byte_d;
    logic [31:0]               counter_q, counter_d;
    logic                      halted_q, halted_d;
    logic [TX_DEPTH_LOG-1:0]   wr_ptr_q, wr_ptr_d;
    logic [TX_DEPTH_LOG-1:0]   rd_ptr_q, rd_ptr_d;
    logic [TX_DEPTH_LOG:0]     count_q, count_d;
    logic                      full_q, full_d;
    logic [7:0]                tx_mem [TX_DEPTH];

    logic       io_acc, io_rx_addr, io_cnt_addr, io_ctrl_addr;
    logic       wr_cmd, push_req, push_ok, tx_pop;
    logic [7:0] push_byte;
    logic [7:0] cnt_read_byte;
    logic [7:0] live_bytes [4];
    logic       unused_addr_bits;

    assign unused_addr_bits = ^mem_a[31:18];

    assign io_acc       = (mem_a[17:16] == 2'b11);
    assign io_rx_addr   = io_acc && (mem_a[15:0] == 16'h0000);
    assign io_cnt_addr  = io_acc && (mem_a[15:2] == 14'h0001);
    assign io_ctrl_addr = io_acc && (mem_a[15:0] == 16'h0004);

    assign ram_a    = mem_a[RAM_ADDR_WIDTH-1:0];
    assign ram_dout = mem_dout;
    assign ram_we   = rdy_in && mem_wr && !io_acc;
    assign rx_pop   = rdy_in && !mem_wr && io_rx_addr && rx_valid;

`ifdef MEM_IO_CLK_SNAPSHOT_EN
    logic [31:0] snap_q, snap_d;
    logic [7:0]  snap_bytes [4];
`endif

    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt_lane
        assign live_bytes[gi] = counter_q[8*gi +: 8];
`ifdef MEM_IO_CLK_SNAPSHOT_EN
        assign snap_bytes[gi] = snap_q[8*gi +: 8];
`endif
    end

`ifdef MEM_IO_CLK_SNAPSHOT_EN
    // Byte 0 comes live while the same read loads the snapshot for bytes 1..3.
    assign cnt_read_byte = (mem_a[1:0] == 2'b00) ? live_bytes[0] : snap_bytes[mem_a[1:0]];
    assign snap_d        = (rdy_in && !mem_wr && io_ctrl_addr) ? counter_q : snap_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            snap_q <= 32'h0;
        end else begin
            snap_q <= snap_d;
        end
    end
`else
    assign cnt_read_byte = live_bytes[mem_a[1:0]];
`endif

    assign tx_valid       = (count_q != '0);
    assign tx_data        = tx_mem[rd_ptr_q];
    assign tx_pop         = tx_valid && tx_ready;
    assign io_buffer_full = full_q;
    assign halted         = halted_q;

    assign wr_cmd    = rdy_in && mem_wr && io_acc && !halted_q;
    assign push_req  = wr_cmd && ((io_rx_addr && (mem_dout != 8'h00)) || io_ctrl_addr);
    assign push_byte = io_ctrl_addr ? 8'h00 : mem_dout;
    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign push_ok   = push_req && ((count_q != DEPTH_C) || tx_pop);

    always_comb begin
        rd_sel_d   = SEL_ZERO;
        rx_byte_d  = rx_byte_q;
        cnt_byte_d = cnt_byte_q;
        if (!mem_wr) begin
            if (!io_acc) begin
                rd_sel_d = SEL_RAM;
            end else if (io_rx_addr) begin
                rd_sel_d  = SEL_RX;
                rx_byte_d = rx_valid ? rx_data : 8'h00;
            end else if (io_cnt_addr) begin
                rd_sel_d   = SEL_CNT;
                cnt_byte_d = cnt_read_byte;
            end
        end
    end

    always_comb begin
        counter_d = halted_q ? counter_q : counter_q + 32'd1;
        halted_d  = halted_q || (wr_cmd && io_ctrl_addr);
        wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = tx_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q;
        if (push_ok && !tx_pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && tx_pop) begin
            count_d = count_q - 1'b1;
        end
        full_d = ((DEPTH_C - count_d) <= MARGIN_C);
    end

    always_comb begin
        case (rd_sel_q)
            SEL_RAM: mem_din = ram_din;
            SEL_RX:  mem_din = rx_byte_q;
            SEL_CNT: mem_din = cnt_byte_q;
            default: mem_din = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_sel_q   <= SEL_ZERO;
            rx_byte_q  <= 8'h00;
            cnt_byte_q <= 8'h00;
            counter_q  <= 32'h0;
            halted_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
        end else begin
            rd_sel_q   <= rd_sel_d;
            rx_byte_q  <= rx_byte_d;
            cnt_byte_q <= cnt_byte_d;
            counter_q  <= counter_d;
            halted_q   <= halted_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            tx_mem[wr_ptr_q] <= push_byte;
        end
    end
endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: vector table, directed corner sequences and a random run
// against a queue/array reference model.
`timescale 1ns/1ps
module tb_mem_io_bridge;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b0;
    logic [31:0] mem_a = 32'h0;
    logic [7:0]  mem_dout = 8'h0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_we;
    logic [7:0]  ram_din;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        rx_pop;
    logic        halted;

    always #5 clk_in = ~clk_in;

    mem_io_bridge dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
        .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .ram_a(ram_a), .ram_dout(ram_dout), .ram_we(ram_we), .ram_din(ram_din),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
        .halted(halted)
    );

    // External synchronous RAM with one cycle of read latency.
    logic [7:0] ram_mem [0:131071];
    always @(posedge clk_in) begin
        if (ram_we) ram_mem[ram_a] <= ram_dout;
        ram_din <= ram_mem[ram_a];
    end

    // Bytes actually handed to the UART.
    byte unsigned tx_seen[$];
    always @(negedge clk_in) begin
        if (rst_in && tx_valid && tx_ready) tx_seen.push_back(tx_data);
    end

    // Reference model state.
    int unsigned  m_cnt;
    int unsigned  m_snap;
    bit           m_halt;
    byte unsigned m_q[$];
    byte unsigned m_ram [int];

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          rdy;
        bit          wr;
        logic [31:0] addr;
        logic [7:0]  dout;
        bit          exp_we;
        bit          chk_din;
        logic [7:0]  exp_din;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] cnt_byte(input logic [1:0] k);
`ifdef MEM_IO_CLK_SNAPSHOT_EN
        if (k != 2'b00) return m_snap[8*k +: 8];
`endif
        return m_cnt[8*k +: 8];
    endfunction

    task automatic set_bus(input bit rdy, input bit wr, input logic [31:0] addr, input logic [7:0] dout);
        rdy_in = rdy; mem_wr = wr; mem_a = addr; mem_dout = dout;
    endtask

    task automatic idle_bus();
        set_bus(1'b1, 1'b0, 32'h0, 8'h0);
    endtask

    // One bus cycle: check combinational outputs, advance the model, clock, check registered outputs.
    task automatic step();
        logic [17:0] a;
        bit          io, din_chk, exp_we, exp_pop, pop;
        logic [7:0]  exp_din;
        #1;
        a       = mem_a[17:0];
        io      = (a[17:16] == 2'b11);
        exp_we  = rdy_in && mem_wr && !io;
        exp_pop = rdy_in && !mem_wr && (a == 18'h30000) && rx_valid;
        chk("ram_we", ram_we, exp_we);
        chk("rx_pop", rx_pop, exp_pop);
        chk("ram_a", ram_a, a[16:0]);
        chk("tx_valid", tx_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("tx_data", tx_data, m_q[0]);

        din_chk = 1'b0;
        exp_din = 8'h00;
        if (!mem_wr) begin
            din_chk = 1'b1;
            if (!io) begin
                if (m_ram.exists(int'(a[16:0]))) exp_din = m_ram[int'(a[16:0])];
                else din_chk = 1'b0;
            end else if (a == 18'h30000) begin
                exp_din = rx_valid ? rx_data : 8'h00;
            end else if (a[17:2] == 16'hC001) begin
                exp_din = cnt_byte(a[1:0]);
            end
`ifdef MEM_IO_CLK_SNAPSHOT_EN
            if (rdy_in && a == 18'h30004) m_snap = m_cnt;
`endif
        end

        pop = (m_q.size() != 0) && tx_ready;
        if (pop) void'(m_q.pop_front());
        if (!m_halt) m_cnt++;
        if (rdy_in && mem_wr) begin
            if (!io) begin
                m_ram[int'(a[16:0])] = mem_dout;
            end else if (!m_halt) begin
                if (a == 18'h30000 && mem_dout != 8'h00) begin
                    if (m_q.size() < 8) m_q.push_back(mem_dout);
                end else if (a == 18'h30004) begin
                    if (m_q.size() < 8) m_q.push_back(8'h00);
                    m_halt = 1'b1;
                end
            end
        end

        @(posedge clk_in);
        #1;
        if (din_chk) chk("mem_din", mem_din, exp_din);
        chk("io_buffer_full", io_buffer_full, (8 - m_q.size()) <= 2);
        chk("halted", halted, m_halt);
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        idle_bus();
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        m_cnt = 0; m_snap = 0; m_halt = 1'b0;
        m_q.delete();
        tx_seen.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned val;
        vecs[0] = '{1'b1, 1'b1, 32'h0000_1234, 8'h5A, 1'b1, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_1234, 8'h00, 1'b0, 1'b1, 8'h5A};
        vecs[2] = '{1'b1, 1'b0, 32'hABC2_1234, 8'h00, 1'b0, 1'b1, 8'h5A};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_1234, 8'hFF, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_1234, 8'h00, 1'b0, 1'b1, 8'h5A};
        vecs[5] = '{1'b1, 1'b0, 32'h0003_0008, 8'h00, 1'b0, 1'b1, 8'h00};
        vecs[6] = '{1'b1, 1'b1, 32'h0001_FFFF, 8'hC3, 1'b1, 1'b0, 8'h00};
        vecs[7] = '{1'b1, 1'b0, 32'h0001_FFFF, 8'h00, 1'b0, 1'b1, 8'hC3};

        // Reset values, sampled while reset is held.
        rst_in = 1'b0;
        idle_bus();
        #22;
        chk("reset mem_din", mem_din, 8'h00);
        chk("reset io_buffer_full", io_buffer_full, 1'b0);
        chk("reset ram_we", ram_we, 1'b0);
        chk("reset tx_valid", tx_valid, 1'b0);
        chk("reset rx_pop", rx_pop, 1'b0);
        chk("reset halted", halted, 1'b0);
        do_reset();

        // RAM decode / write / read-return table.
        for (int i = 0; i < 8; i++) begin
            set_bus(vecs[i].rdy, vecs[i].wr, vecs[i].addr, vecs[i].dout);
            #1;
            chk("vec ram_we", ram_we, vecs[i].exp_we);
            step();
            if (vecs[i].chk_din) chk("vec mem_din", mem_din, vecs[i].exp_din);
            $display("vec %0d: rdy=%0d wr=%0d a=0x%08h dout=0x%02h din=0x%02h", i,
                     vecs[i].rdy, vecs[i].wr, vecs[i].addr, vecs[i].dout, mem_din);
        end

        // UART output of 'A','B','C'; a zero byte is not pushed.
        tx_seen.delete();
        tx_ready = 1'b1;
        set_bus(1'b1, 1'b1, 32'h0003_0000, 8'h41); step();
        set_bus(1'b1, 1'b1, 32'h0003_0000, 8'h42); step();
        set_bus(1'b1, 1'b1, 32'h0003_0000, 8'h43); step();
        set_bus(1'b1, 1'b1, 32'h0003_0000, 8'h00); step();
        idle_bus();
        repeat (4) step();
        chk("abc count", tx_seen.size(), 3);
        for (int i = 0; i < 3 && i < tx_seen.size(); i++) chk("abc byte", tx_seen[i], 8'h41 + i);
        $display("txabc: %0d bytes emitted", tx_seen.size());

        // Fill without draining: near-full after 6, 9th dropped, drain in order.
        tx_seen.delete();
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            set_bus(1'b1, 1'b1, 32'h0003_0000, 8'h11 + 8'(i));
            step();
            chk("fill io_buffer_full", io_buffer_full, i >= 5);
            $display("fill push %0d: full=%0d", i + 1, io_buffer_full);
        end
        idle_bus();
        tx_ready = 1'b1;
        repeat (12) step();
        chk("fill drained count", tx_seen.size(), 8);
        for (int i = 0; i < 8 && i < tx_seen.size(); i++) chk("fill drained byte", tx_seen[i], 8'h11 + i);
        chk("fill full cleared", io_buffer_full, 1'b0);

        // Counter after 100 idle cycles, read as four bytes.
        do_reset();
        idle_bus();
        repeat (100) step();
        val = 0;
        for (int k = 0; k < 4; k++) begin
            set_bus(1'b1, 1'b0, 32'h0003_0004 + k, 8'h00);
            step();
            val = val | (int'(mem_din) << (8 * k));
        end
        chk("counter after 100", val, 100);
        $display("counter read: %0d", val);

        // Halt: emits 0x00, freezes counter, blocks later IO writes, RAM writes continue.
        tx_seen.delete();
        tx_ready = 1'b1;
        set_bus(1'b1, 1'b1, 32'h0003_0004, 8'h99); step();
        chk("halt set", halted, 1'b1);
        idle_bus();
        repeat (3) step();
        chk("halt tx count", tx_seen.size(), 1);
        if (tx_seen.size() > 0) chk("halt tx byte", tx_seen[0], 8'h00);
        set_bus(1'b1, 1'b0, 32'h0003_0004, 8'h00); step();
        chk("frozen counter a", mem_din, m_cnt[7:0]);
        idle_bus();
        repeat (5) step();
        set_bus(1'b1, 1'b0, 32'h0003_0004, 8'h00); step();
        chk("frozen counter b", mem_din, m_cnt[7:0]);
        set_bus(1'b1, 1'b1, 32'h0003_0000, 8'h5A); step();
        idle_bus();
        repeat (3) step();
        chk("halted no tx", tx_seen.size(), 1);
        set_bus(1'b1, 1'b1, 32'h0000_0200, 8'h77); step();
        set_bus(1'b1, 1'b0, 32'h0000_0200, 8'h00); step();
        chk("halted ram readback", mem_din, 8'h77);
        $display("halt: halted=%0d tx_bytes=%0d", halted, tx_seen.size());

        // rdy_in low suppresses side effects but not read data.
        do_reset();
        set_bus(1'b1, 1'b1, 32'h0000_0300, 8'h12); step();
        set_bus(1'b0, 1'b1, 32'h0000_0300, 8'hEE); #1; chk("rdy0 ram_we", ram_we, 1'b0); step();
        set_bus(1'b0, 1'b1, 32'h0003_0000, 8'h51); step();
        chk("rdy0 no push", tx_valid, 1'b0);
        set_bus(1'b1, 1'b0, 32'h0000_0300, 8'h00); step();
        chk("rdy0 ram kept", mem_din, 8'h12);
        rx_valid = 1'b1; rx_data = 8'h3C;
        set_bus(1'b0, 1'b0, 32'h0003_0000, 8'h00); #1; chk("rdy0 rx_pop", rx_pop, 1'b0); step();
        chk("rdy0 rx data", mem_din, 8'h3C);
        set_bus(1'b1, 1'b0, 32'h0003_0000, 8'h00); #1; chk("rdy1 rx_pop", rx_pop, 1'b1); step();
        rx_valid = 1'b0;
        set_bus(1'b1, 1'b0, 32'h0003_0000, 8'h00); step();
        chk("rx empty reads zero", mem_din, 8'h00);
        $display("rdy: low-rdy side effects checked");

        // Asynchronous reset in the middle of traffic.
        tx_ready = 1'b0;
        set_bus(1'b1, 1'b1, 32'h0003_0000, 8'h61); step();
        set_bus(1'b1, 1'b1, 32'h0003_0000, 8'h62); step();
        set_bus(1'b1, 1'b1, 32'h0003_0004, 8'h01); step();
        set_bus(1'b1, 1'b0, 32'h0003_0000, 8'h00);
        #2;
        rst_in = 1'b0;
        #1;
        chk("async rst tx_valid", tx_valid, 1'b0);
        chk("async rst halted", halted, 1'b0);
        chk("async rst mem_din", mem_din, 8'h00);
        do_reset();
        tx_ready = 1'b1;
        idle_bus();
        repeat (5) step();
        chk("rst lost tx bytes", tx_seen.size(), 0);
        $display("midreset: tx_bytes=%0d", tx_seen.size());

        // Randomized traffic against the model (no halt writes).
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            int unsigned r, hi, off;
            logic [17:0] a18;
            bit          wr;
            r  = $urandom_range(0, 9);
            hi = $urandom;
            wr = $urandom_range(0, 1) != 0;
            if (r <= 4) begin
                a18 = 18'h00100 + 18'($urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0) a18 = a18 | 18'h20000;
            end else if (r <= 8) begin
                off = $urandom_range(0, 8);
                if (wr && off == 4) off = 0;
                a18 = 18'h30000 + 18'(off);
            end else begin
                a18 = 18'h1FFF0 + 18'($urandom_range(0, 15));
            end
            set_bus($urandom_range(0, 4) != 0, wr, {hi[31:18], a18},
                    ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
            tx_ready = $urandom_range(0, 2) == 0;
            rx_valid = $urandom_range(0, 1) != 0;
            rx_data  = 8'($urandom);
            step();
        end
        $display("random: 1500 cycles, %0d errors so far", errors);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
